lfsr_range_gen: RTL and testbench

LFSR_RANGE_GEN -- requirements
Module: lfsr_range_gen

---
 rtl/lfsr_pkg.sv | 26 ++
 rtl/lfsr_core.sv | 37 +++
 rtl/lfsr_range_gen.sv | 165 ++++++++++++++++
 tb/tb_lfsr_range_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR range generator: tap table, FSM states and
// the helper that pulls a candidate field out of the LFSR value.
package lfsr_pkg;

  // Maximal-length tap masks, bit i set means s[i] feeds the XOR; index = WIDTH.
  localparam logic [15:0] TAP_MASK [4:16] = '{
    16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110, 16'h0240,
    16'h0500, 16'h0829, 16'h100D, 16'h2015, 16'h6000, 16'hB400
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  function automatic logic [15:0] field_extract(input logic [15:0] value, input int fw);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < fw) r[i] = value[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci shift-left LFSR register with seed load; never holds zero.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int              WIDTH      = 16,
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             advance,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next
);

  localparam logic [15:0]      MASK_FULL = TAP_MASK[WIDTH];
  localparam logic [WIDTH-1:0] MASK      = MASK_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] seed_fix;

  assign next     = {state_q[WIDTH-2:0], ^(state_q & MASK)};
  assign seed_fix = (seed == '0) ? WIDTH'(1) : seed;
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_SEED;
    end else if (load) begin
      state_q <= seed_fix;
    end else if (advance) begin
      state_q <= next;
    end
  end

endmodule

// File: rtl/lfsr_range_gen.sv
// Draws NUM_FIELDS bounded random fields from an LFSR by rejection sampling,
// falling back to 0 for a field after MAX_TRIES rejected candidates.
module lfsr_range_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter int               FIELD_W    = 3,
  parameter int               NUM_FIELDS = 2,
  parameter int               MAX_TRIES  = 8,
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [WIDTH-1:0]              seed,
  input  logic                          step,
  input  logic                          req,
  input  logic [FIELD_W-1:0]            limit,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [NUM_FIELDS*FIELD_W-1:0] fields,
  output logic                          fallback,
  output logic                          busy,
  output logic [WIDTH-1:0]              lfsr_state
);

  localparam int IDX_W = 4;

  fsm_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       tries_q, tries_d;
  logic [FIELD_W-1:0] limit_q, limit_d;
  logic             out_valid_q, out_valid_d;
  logic             fallback_q, fallback_d;

  logic               advance;
  logic [WIDTH-1:0]   lfsr_next;
  logic [15:0]        cand_full;
  logic [FIELD_W-1:0] cand;
  logic               accept;
  logic               exhausted;
  logic               wr_en;
  logic [FIELD_W-1:0] wr_val;

  lfsr_core #(
    .WIDTH      (WIDTH),
    .RESET_SEED (RESET_SEED)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .seed    (seed),
    .advance (advance),
    .state   (lfsr_state),
    .next    (lfsr_next)
  );

  // The candidate is taken from the value the LFSR moves to on this edge.
  assign cand_full = field_extract(16'(lfsr_next), FIELD_W);
  assign cand      = cand_full[FIELD_W-1:0];
  assign accept    = (limit_q == '0) || (cand < limit_q);
  assign exhausted = ({1'b0, tries_q} + 9'd1) == 9'(MAX_TRIES);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tries_d     = tries_q;
    limit_d     = limit_q;
    out_valid_d = out_valid_q;
    fallback_d  = fallback_q;
    advance     = 1'b0;
    wr_en       = 1'b0;
    wr_val      = cand;

    case (state_q)
      ST_IDLE: begin
        advance = step;
        if (req) begin
          state_d    = ST_DRAW;
          idx_d      = '0;
          tries_d    = '0;
          limit_d    = limit;
          fallback_d = 1'b0;
        end
      end
      ST_DRAW: begin
        advance = 1'b1;
        if (accept) begin
          wr_en = 1'b1;
        end else if (exhausted) begin
          wr_en      = 1'b1;
          wr_val     = '0;
          fallback_d = 1'b1;
        end else begin
          tries_d = tries_q + 8'd1;
        end
        if (wr_en) begin
          tries_d = '0;
          if (idx_q == IDX_W'(NUM_FIELDS - 1)) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A load aborts whatever is in flight and leaves fallback as it was.
    if (load) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      idx_d       = '0;
      tries_d     = '0;
      limit_d     = limit_q;
      fallback_d  = fallback_q;
      wr_en       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      tries_q     <= '0;
      limit_q     <= '0;
      out_valid_q <= 1'b0;
      fallback_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tries_q     <= tries_d;
      limit_q     <= limit_d;
      out_valid_q <= out_valid_d;
      fallback_q  <= fallback_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      logic [FIELD_W-1:0] field_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          field_q <= '0;
        end else if (wr_en && (idx_q == IDX_W'(gi))) begin
          field_q <= wr_val;
        end
      end
      assign fields[gi*FIELD_W +: FIELD_W] = field_q;
    end
  endgenerate

  assign out_valid = out_valid_q;
  assign fallback  = fallback_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lfsr_range_gen.sv
// Randomized self-checking bench for lfsr_range_gen against a draw-level model.
module tb_lfsr_range_gen;

  localparam int W  = 6;
  localparam int FW = 3;
  localparam int NF = 2;
  localparam int MT = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           load = 1'b0;
  logic [W-1:0]   seed = '0;
  logic           step = 1'b0;
  logic           req = 1'b0;
  logic [FW-1:0]  limit = '0;
  logic           out_ready = 1'b0;
  logic           out_valid;
  logic [NF*FW-1:0] fields;
  logic           fallback;
  logic           busy;
  logic [W-1:0]   lfsr_state;

  int n_checks = 0;
  int n_errors = 0;
  int m_lfsr;

  always #5 clk = ~clk;

  lfsr_range_gen #(
    .WIDTH      (W),
    .FIELD_W    (FW),
    .NUM_FIELDS (NF),
    .MAX_TRIES  (MT),
    .RESET_SEED (6'd1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .seed       (seed),
    .step       (step),
    .req        (req),
    .limit      (limit),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .fields     (fields),
    .fallback   (fallback),
    .busy       (busy),
    .lfsr_state (lfsr_state)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Polynomial x^6 + x^5 + 1 written as plain arithmetic on an integer.
  function automatic int lfsr_adv(input int s);
    return ((s << 1) & 63) | (((s >> 5) ^ (s >> 4)) & 1);
  endfunction

  task automatic model_draw(input int lim, output int exp_fields, output int exp_fb,
                            output int exp_cyc);
    int c;
    int tries;
    exp_fields = 0;
    exp_fb     = 0;
    exp_cyc    = 0;
    for (int f = 0; f < NF; f++) begin
      tries = 0;
      forever begin
        m_lfsr = lfsr_adv(m_lfsr);
        exp_cyc++;
        c = m_lfsr % (1 << FW);
        if (lim == 0 || c < lim) begin
          exp_fields = exp_fields | (c << (f * FW));
          break;
        end
        tries++;
        if (tries == MT) begin
          exp_fb = 1;
          break;
        end
      end
    end
  endtask

  task automatic do_load(input int s);
    seed = W'(s);
    load = 1'b1;
    tick();
    load = 1'b0;
    m_lfsr = (s % 64 == 0) ? 1 : s % 64;
    check_val("load_state", 32'(lfsr_state), 32'(m_lfsr));
  endtask

  task automatic do_draw(input int lim, input int hold);
    int exp_fields, exp_fb, exp_cyc, n;
    model_draw(lim, exp_fields, exp_fb, exp_cyc);
    limit = FW'(lim);
    step  = 1'b0;
    req   = 1'b1;
    tick();
    req = 1'b0;
    check_val("busy_draw", 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check_val("latency", 32'(n), 32'(exp_cyc));
    check_val("fields", 32'(fields), 32'(exp_fields));
    check_val("fallback", 32'(fallback), 32'(exp_fb));
    check_val("lfsr_done", 32'(lfsr_state), 32'(m_lfsr));
    for (int i = 0; i < hold; i++) begin
      step = 1'($urandom);
      req  = 1'($urandom);
      tick();
      check_val("hold_valid", 32'(out_valid), 32'd1);
      check_val("hold_fields", 32'(fields), 32'(exp_fields));
      check_val("hold_lfsr", 32'(lfsr_state), 32'(m_lfsr));
    end
    step = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    req = 1'b0;
    check_val("valid_drop", 32'(out_valid), 32'd0);
    check_val("busy_idle", 32'(busy), 32'd0);
    $display("draw limit=%0d fields=0x%0h fallback=%0d cycles=%0d", lim, fields, fallback, n);
  endtask

  initial begin
    int exp_seq [5];
    int cnt;
    int nidle;
    exp_seq = '{2, 4, 8, 16, 33};

    tick();
    tick();
    reset = 1'b0;
    check_val("rst_lfsr", 32'(lfsr_state), 32'd1);
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_fields", 32'(fields), 32'd0);
    check_val("rst_fallback", 32'(fallback), 32'd0);

    // Stepping sequence and full period from seed 1.
    do_load(1);
    step = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("step_seq", 32'(lfsr_state), 32'(exp_seq[i]));
    end
    cnt = 5;
    while (lfsr_state != 6'd1 && cnt < 200) begin
      tick();
      cnt++;
    end
    step = 1'b0;
    check_val("period", 32'(cnt), 32'd63);
    m_lfsr = 1;
    $display("period test: %0d steps back to 1", cnt);

    do_load(0);
    check_val("zero_seed", 32'(lfsr_state), 32'd1);

    // Full-range draw from seed 1 gives field0=2, field1=4.
    do_draw(0, 3);
    check_val("det_fields", 32'(fields), 32'h22);
    check_val("det_fallback", 32'(fallback), 32'd0);

    // limit=1 from seed 1: both candidates of field0 rejected -> fallback.
    do_load(1);
    do_draw(1, 10);
    check_val("lim1_fields", 32'(fields), 32'd0);
    check_val("lim1_fallback", 32'(fallback), 32'd1);

    // Abort a draw with a load.
    limit = '0;
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    seed = 6'h15;
    load = 1'b1;
    tick();
    load = 1'b0;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_valid", 32'(out_valid), 32'd0);
    check_val("abort_lfsr", 32'(lfsr_state), 32'h15);
    m_lfsr = 'h15;
    $display("abort: lfsr=0x%0h busy=%0d", lfsr_state, busy);
    do_draw(0, 2);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) do_load(int'($urandom_range(0, 63)));
      nidle = int'($urandom_range(0, 6));
      for (int k = 0; k < nidle; k++) begin
        step = 1'($urandom);
        tick();
        if (step) m_lfsr = lfsr_adv(m_lfsr);
      end
      step = 1'b0;
      check_val("idle_lfsr", 32'(lfsr_state), 32'(m_lfsr));
      do_draw(int'($urandom_range(0, 7)), int'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
